// File: rtl/bsg_axil_to_mcl_pkg.sv
// Shared types and constants for the AXI-Lite-to-MCL bridge and its read-side arbiter.
package bsg_axil_to_mcl_pkg;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2,
        RD_RESP = 2'd3
    } rd_arb_state_e;

    localparam logic [1:0] axil_resp_okay_gp   = 2'b00;
    localparam logic [1:0] axil_resp_slverr_gp = 2'b10;
    localparam logic [1:0] axil_resp_decerr_gp = 2'b11;

    // A single master still needs a one-bit index so the grant registers stay declarable.
    function automatic int rd_arb_idx_width(input int num_masters);
        return (num_masters > 1) ? $clog2(num_masters) : 1;
    endfunction

endpackage

// File: rtl/bsg_axil_rr_arbiter.sv
// Combinational round-robin pick: search starts just above last_grant_i and wraps to 0.
module bsg_axil_rr_arbiter
    import bsg_axil_to_mcl_pkg::*;
#(
    parameter  int num_masters_p = 2,
    localparam int idx_width_lp  = rd_arb_idx_width(num_masters_p)
) (
    input  logic [num_masters_p-1:0] req_i,
    input  logic [idx_width_lp-1:0]  last_grant_i,
    output logic [num_masters_p-1:0] grant_oh_o,
    output logic [idx_width_lp-1:0]  grant_idx_o,
    output logic                     grant_v_o
);

    logic [num_masters_p-1:0] req_hi;
    logic [num_masters_p-1:0] pick;

    // Requesters above the last winner take precedence; otherwise fall back to the lowest index.
    always_comb begin
        req_hi = '0;
        for (int i = 0; i < num_masters_p; i++) begin
            req_hi[i] = req_i[i] && (i > int'(last_grant_i));
        end
        pick = (|req_hi) ? req_hi : req_i;

        grant_oh_o  = '0;
        grant_idx_o = '0;
        for (int i = num_masters_p - 1; i >= 0; i--) begin
            if (pick[i]) begin
                grant_oh_o    = '0;
                grant_oh_o[i] = 1'b1;
                grant_idx_o   = i[idx_width_lp-1:0];
            end
        end
        grant_v_o = |req_i;
    end

endmodule

// File: rtl/bsg_axil_rd_arbiter.sv
// Shares one AXI-Lite read slave among several read masters, one read outstanding at a time.
//
// state   | meaning
// --------+-------------------------------------------------------------
// RD_IDLE | arbitrate; winner's AR handshake is combinational this cycle
// RD_ADDR | replay latched address to the slave until m_arready_i
// RD_DATA | m_rready_o high; wait for the slave's read data
// RD_RESP | hold captured data/resp to the granted master until it accepts
module bsg_axil_rd_arbiter
    import bsg_axil_to_mcl_pkg::*;
#(
    parameter int num_masters_p = 2,
    parameter int addr_width_p  = 32,
    parameter int data_width_p  = 32
) (
    input  logic                                        clk_i,
    input  logic                                        reset_n_i,

    input  logic [num_masters_p-1:0][addr_width_p-1:0]  s_araddr_i,
    input  logic [num_masters_p-1:0]                    s_arvalid_i,
    output logic [num_masters_p-1:0]                    s_arready_o,
    output logic [data_width_p-1:0]                     s_rdata_o,
    output logic [1:0]                                  s_rresp_o,
    output logic [num_masters_p-1:0]                    s_rvalid_o,
    input  logic [num_masters_p-1:0]                    s_rready_i,

    output logic [addr_width_p-1:0]                     m_araddr_o,
    output logic                                        m_arvalid_o,
    input  logic                                        m_arready_i,
    input  logic [data_width_p-1:0]                     m_rdata_i,
    input  logic [1:0]                                  m_rresp_i,
    input  logic                                        m_rvalid_i,
    output logic                                        m_rready_o
);

    localparam int idx_width_lp = rd_arb_idx_width(num_masters_p);
    localparam logic [idx_width_lp-1:0] last_grant_rst_lp = idx_width_lp'(num_masters_p - 1);

    rd_arb_state_e              state_q, state_d;
    logic [idx_width_lp-1:0]    grant_q, grant_d;
    logic [idx_width_lp-1:0]    last_grant_q, last_grant_d;
    logic [addr_width_p-1:0]    addr_q, addr_d;
    logic [data_width_p-1:0]    rdata_q, rdata_d;
    logic [1:0]                 rresp_q, rresp_d;
    logic                       arvalid_q, arvalid_d;
    logic                       rready_q, rready_d;
    logic [num_masters_p-1:0]   rvalid_q, rvalid_d;

    logic [num_masters_p-1:0]   arb_grant_oh;
    logic [idx_width_lp-1:0]    arb_grant_idx;
    logic                       arb_grant_v;
    logic [addr_width_p-1:0]    arb_addr;
    logic [num_masters_p-1:0]   grant_q_oh;
    logic                       granted_rready;

    bsg_axil_rr_arbiter #(
        .num_masters_p (num_masters_p)
    ) rr_arb (
        .req_i        (s_arvalid_i),
        .last_grant_i (last_grant_q),
        .grant_oh_o   (arb_grant_oh),
        .grant_idx_o  (arb_grant_idx),
        .grant_v_o    (arb_grant_v)
    );

    // One-hot muxes avoid indexing by a grant value that may be wider than the master count.
    always_comb begin
        arb_addr       = '0;
        grant_q_oh     = '0;
        granted_rready = 1'b0;
        for (int i = 0; i < num_masters_p; i++) begin
            if (arb_grant_oh[i]) begin
                arb_addr = arb_addr | s_araddr_i[i];
            end
            if (grant_q == i[idx_width_lp-1:0]) begin
                grant_q_oh[i]  = 1'b1;
                granted_rready = s_rready_i[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        rvalid_d     = rvalid_q;

        case (state_q)
            RD_IDLE: begin
                if (arb_grant_v) begin
                    addr_d    = arb_addr;
                    grant_d   = arb_grant_idx;
                    arvalid_d = 1'b1;
                    state_d   = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (m_arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_rvalid_i) begin
                    rdata_d  = m_rdata_i;
                    rresp_d  = m_rresp_i;
                    rready_d = 1'b0;
                    rvalid_d = grant_q_oh;
                    state_d  = RD_RESP;
                end
            end
            RD_RESP: begin
                if (granted_rready) begin
                    last_grant_d = grant_q;
                    rvalid_d     = '0;
                    state_d      = RD_IDLE;
                end
            end
            default: begin
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                rvalid_d  = '0;
                state_d   = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= RD_IDLE;
            grant_q      <= '0;
            last_grant_q <= last_grant_rst_lp;
            addr_q       <= '0;
            rdata_q      <= '0;
            rresp_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            rvalid_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            rvalid_q     <= rvalid_d;
        end
    end

    // Only AR ready is combinational; everything toward the slave and the R channel is a flop.
    assign s_arready_o = (state_q == RD_IDLE) ? arb_grant_oh : '0;
    assign s_rvalid_o  = rvalid_q;
    assign s_rdata_o   = rdata_q;
    assign s_rresp_o   = rresp_q;
    assign m_araddr_o  = addr_q;
    assign m_arvalid_o = arvalid_q;
    assign m_rready_o  = rready_q;

endmodule

// File: tb/tb_bsg_axil_rd_arbiter.sv
// Scoreboard bench for bsg_axil_rd_arbiter: directed reads, slave model, R-channel monitor.
`timescale 1ns/1ps
module tb_bsg_axil_rd_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic                 clk_i = 1'b0;
    logic                 reset_n_i;
    logic [N-1:0][AW-1:0] s_araddr_i;
    logic [N-1:0]         s_arvalid_i;
    logic [N-1:0]         s_arready_o;
    logic [DW-1:0]        s_rdata_o;
    logic [1:0]           s_rresp_o;
    logic [N-1:0]         s_rvalid_o;
    logic [N-1:0]         s_rready_i;
    logic [AW-1:0]        m_araddr_o;
    logic                 m_arvalid_o;
    logic                 m_arready_i;
    logic [DW-1:0]        m_rdata_i;
    logic [1:0]           m_rresp_i;
    logic                 m_rvalid_i;
    logic                 m_rready_o;

    bsg_axil_rd_arbiter #(
        .num_masters_p (N),
        .addr_width_p  (AW),
        .data_width_p  (DW)
    ) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .s_araddr_i  (s_araddr_i),
        .s_arvalid_i (s_arvalid_i),
        .s_arready_o (s_arready_o),
        .s_rdata_o   (s_rdata_o),
        .s_rresp_o   (s_rresp_o),
        .s_rvalid_o  (s_rvalid_o),
        .s_rready_i  (s_rready_i),
        .m_araddr_o  (m_araddr_o),
        .m_arvalid_o (m_arvalid_o),
        .m_arready_i (m_arready_i),
        .m_rdata_i   (m_rdata_i),
        .m_rresp_i   (m_rresp_i),
        .m_rvalid_i  (m_rvalid_i),
        .m_rready_o  (m_rready_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [N-1:0]  vec;
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] mq0[$];
    logic [AW-1:0] mq1[$];
    int            rcyc_q[$];

    int           up_hs_cnt = 0;
    int           sl_ar_cnt = 0;
    int           ar_wait   = 0;
    int           r_wait    = 0;
    bit           sl_kill   = 1'b0;
    logic [N-1:0] hs_prev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Slave model data tag: 0x1000 maps to 0xDEADBEEF.
    function automatic logic [DW-1:0] tag(input logic [AW-1:0] a);
        return a ^ 32'hDEAD_AEEF;
    endfunction

    function automatic logic [1:0] sl_resp(input logic [AW-1:0] a);
        return (a == 32'h0000_F000) ? 2'b11 : 2'b00;
    endfunction

    task automatic push_exp(input int m, input logic [DW-1:0] d, input logic [1:0] r);
        exp_t e;
        e.vec  = '0;
        e.vec[m] = 1'b1;
        e.data = d;
        e.resp = r;
        exp_q.push_back(e);
    endtask

    task automatic issue(input int m, input logic [AW-1:0] a);
        if (m == 0) mq0.push_back(a);
        else        mq1.push_back(a);
    endtask

    task automatic wait_up(input int k, input string name);
        for (int t = 0; t < 200 && up_hs_cnt < k; t++) begin
            @(negedge clk_i);
            #1;
        end
        if (up_hs_cnt < k) timeout_fail(name);
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(negedge clk_i);
        if (exp_q.size() != 0) timeout_fail(name);
    endtask

    // Upstream masters: present queue head, pop one cycle after the AR handshake edge.
    initial begin
        logic [AW-1:0] dummy;
        s_arvalid_i = '0;
        s_araddr_i  = '0;
        hs_prev     = '0;
        forever begin
            @(negedge clk_i);
            if (hs_prev[0]) begin dummy = mq0.pop_front(); up_hs_cnt++; end
            if (hs_prev[1]) begin dummy = mq1.pop_front(); up_hs_cnt++; end
            s_arvalid_i[0] = (mq0.size() != 0);
            s_araddr_i[0]  = (mq0.size() != 0) ? mq0[0] : '0;
            s_arvalid_i[1] = (mq1.size() != 0);
            s_araddr_i[1]  = (mq1.size() != 0) ? mq1[0] : '0;
            #1;
            hs_prev = s_arvalid_i & s_arready_o;
        end
    end

    // Shared slave model with programmable AR and R wait states.
    initial begin
        logic [AW-1:0] sl_addr;
        m_arready_i = 1'b0;
        m_rvalid_i  = 1'b0;
        m_rdata_i   = '0;
        m_rresp_i   = '0;
        forever begin
            @(negedge clk_i);
            if (m_arvalid_o && !sl_kill) begin
                sl_addr = m_araddr_o;
                for (int i = 0; i < ar_wait; i++) begin
                    @(negedge clk_i);
                    chk("ar_addr_stable", m_araddr_o, sl_addr);
                    chk("ar_valid_stable", m_arvalid_o, 1);
                end
                m_arready_i = 1'b1;
                @(negedge clk_i);
                m_arready_i = 1'b0;
                sl_ar_cnt++;
                for (int i = 0; i < r_wait && !sl_kill; i++) begin
                    @(negedge clk_i);
                    if (!sl_kill) chk("no_extra_ar", m_arvalid_o, 0);
                end
                if (!sl_kill) begin
                    m_rdata_i  = tag(sl_addr);
                    m_rresp_i  = sl_resp(sl_addr);
                    m_rvalid_i = 1'b1;
                    @(negedge clk_i);
                    m_rvalid_i = 1'b0;
                end
            end
        end
    end

    // R-channel monitor: every upstream R handshake pops and checks one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #3;
            if (reset_n_i === 1'b1 && (s_rvalid_o & s_rready_i) != '0) begin
                rcyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_r: rvalid=0x%0h data=0x%0h with empty scoreboard", s_rvalid_o, s_rdata_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("r_valid_vec", s_rvalid_o, e.vec);
                    chk("r_data", s_rdata_o, e.data);
                    chk("r_resp", s_rresp_o, e.resp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset_n_i  = 1'b0;
        s_rready_i = '1;

        // Reset values
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_valids", {s_arready_o, s_rvalid_o, m_arvalid_o, m_rready_o}, 0);
        chk("rst_rdata", s_rdata_o, 0);
        chk("rst_rresp", s_rresp_o, 0);
        chk("rst_araddr", m_araddr_o, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        #2;
        chk("idle_valids", {s_arready_o, s_rvalid_o, m_arvalid_o, m_rready_o}, 0);

        // Single read, zero-wait slave: address in cycle 1, response in cycle 3
        base = up_hs_cnt;
        @(posedge clk_i); #2;
        push_exp(0, 32'hDEAD_BEEF, 2'b00);
        issue(0, 32'h0000_1000);
        wait_up(base + 1, "t1_ar_handshake");
        #1;
        chk("t1_m_arvalid_c1", m_arvalid_o, 1);
        chk("t1_m_araddr_c1", m_araddr_o, 32'h0000_1000);
        @(negedge clk_i);
        @(negedge clk_i);
        #2;
        chk("t1_s_rvalid_c3", s_rvalid_o, 2'b01);
        drain("t1_drain");

        // Both masters busy: master 0 won last, so master 1 goes first, then alternate
        rcyc_q.delete();
        @(posedge clk_i); #2;
        for (int k = 0; k < 3; k++) begin
            push_exp(1, tag(32'h200 + 32'(4 * k)), 2'b00);
            push_exp(0, tag(32'h100 + 32'(4 * k)), 2'b00);
        end
        for (int k = 0; k < 3; k++) begin
            issue(0, 32'h100 + 32'(4 * k));
            issue(1, 32'h200 + 32'(4 * k));
        end
        drain("t2_drain");
        chk("t2_count", rcyc_q.size(), 6);
        if (rcyc_q.size() == 6) chk("t2_throughput", rcyc_q[5] - rcyc_q[0], 20);

        // Slave stalls AR for 5 cycles and R for 7
        ar_wait = 5;
        r_wait  = 7;
        base    = sl_ar_cnt;
        @(posedge clk_i); #2;
        push_exp(0, tag(32'h300), 2'b00);
        issue(0, 32'h300);
        drain("t3_drain");
        chk("t3_ar_count", sl_ar_cnt - base, 1);
        ar_wait = 0;
        r_wait  = 0;

        // Granted master stalls R for 10 cycles while master 1 waits
        @(posedge clk_i); #2;
        s_rready_i[0] = 1'b0;
        push_exp(0, tag(32'h400), 2'b00);
        issue(0, 32'h400);
        begin : wait_rv
            int t;
            for (t = 0; t < 100 && !s_rvalid_o[0]; t++) begin
                @(negedge clk_i);
                #1;
            end
            if (!s_rvalid_o[0]) timeout_fail("t4_rvalid");
        end
        @(posedge clk_i); #2;
        push_exp(1, tag(32'h500), 2'b00);
        issue(1, 32'h500);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            #2;
            chk("t4_rdata_stable", s_rdata_o, tag(32'h400));
            chk("t4_rvalid_held", s_rvalid_o, 2'b01);
            chk("t4_arready1_low", s_arready_o[1], 0);
        end
        s_rready_i[0] = 1'b1;
        @(negedge clk_i);
        #2;
        chk("t4_m1_granted_next", s_arready_o, 2'b10);
        drain("t4_drain");

        // DECERR goes only to its requester; the following read is OKAY
        @(posedge clk_i); #2;
        push_exp(0, tag(32'h0000_F000), 2'b11);
        push_exp(1, tag(32'h600), 2'b00);
        issue(0, 32'h0000_F000);
        issue(1, 32'h600);
        drain("t5_drain");

        // Reset while the slave is in its data phase
        r_wait = 20;
        @(posedge clk_i); #2;
        issue(1, 32'h700);
        begin : wait_data
            int t;
            for (t = 0; t < 100 && !m_rready_o; t++) begin
                @(negedge clk_i);
                #1;
            end
            if (!m_rready_o) timeout_fail("t6_data_phase");
        end
        #1;
        sl_kill   = 1'b1;
        reset_n_i = 1'b0;
        #1;
        chk("t6_async_valids", {s_arready_o, s_rvalid_o, m_arvalid_o, m_rready_o}, 0);
        chk("t6_async_araddr", m_araddr_o, 0);
        repeat (3) @(negedge clk_i);
        r_wait    = 0;
        reset_n_i = 1'b1;
        @(negedge clk_i);
        sl_kill = 1'b0;
        @(posedge clk_i); #2;
        push_exp(0, tag(32'h800), 2'b00);
        push_exp(1, tag(32'h900), 2'b00);
        issue(0, 32'h800);
        issue(1, 32'h900);
        drain("t6_drain");

        repeat (4) @(negedge clk_i);
        chk("final_scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bsg_axil_rd_arbiter.md
# bsg_axil_rd_arbiter

Shares one AXI-Lite read slave (the FIFO/monitor read port of the AXI-Lite-to-MCL bridge) among `num_masters_p` upstream AXI-Lite read masters. Arbitration is round-robin and non-preemptive, with exactly one read outstanding. The block latches the winning master's address, replays it to the shared slave, captures the response and returns it to the granted master. It sits between the host-side AXI-Lite interconnect ports and the bridge read slave, so the slave only ever sees single, well-ordered read transactions.

## Interface
Parameters:
- `num_masters_p`, default 2: number of upstream read masters; legal range 1..16.
- `addr_width_p`, default 32: AR address width.
- `data_width_p`, default 32: R data width.

Ports:
- `clk_i`  in  1  sole clock.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `s_araddr_i`  in  `[num_masters_p-1:0][addr_width_p-1:0]`  per-master read address.
- `s_arvalid_i`  in  `[num_masters_p-1:0]`  per-master AR valid.
- `s_arready_o`  out  `[num_masters_p-1:0]`  per-master AR ready.
- `s_rdata_o`  out  `[data_width_p-1:0]`  response data, shared by all masters.
- `s_rresp_o`  out  2  response code, shared by all masters.
- `s_rvalid_o`  out  `[num_masters_p-1:0]`  per-master R valid.
- `s_rready_i`  in  `[num_masters_p-1:0]`  per-master R ready.
- `m_araddr_o`  out  `addr_width_p`  address to the shared slave.
- `m_arvalid_o`  out  1  AR valid to the slave.
- `m_arready_i`  in  1  AR ready from the slave.
- `m_rdata_i`  in  `data_width_p`  read data from the slave.
- `m_rresp_i`  in  2  response code from the slave.
- `m_rvalid_i`  in  1  R valid from the slave.
- `m_rready_o`  out  1  R ready to the slave.

## Operation
- FSM states: `IDLE`, `ADDR`, `DATA`, `RESP`.
- **IDLE:**
  - The arbiter picks one requester among asserted `s_arvalid_i`. Priority starts at `last_grant_r+1` and wraps modulo `num_masters_p`.
  - `s_arready_o[g]` is asserted combinationally in the same cycle, for the winner only.
  - On that handshake: `addr_r <= s_araddr_i[g]`, `grant_r <= g`, go to `ADDR`.
  - With no request, the FSM stays in `IDLE`.
- **ADDR:**
  - `m_arvalid_o=1` and `m_araddr_o=addr_r`. Address and valid are held stable until `m_arready_i`.
  - On `m_arready_i`, go to `DATA`.
- **DATA:**
  - `m_rready_o=1`.
  - On `m_rvalid_i`, capture `m_rdata_i` and `m_rresp_i` into `rdata_r` and `rresp_r`, then go to `RESP`.
- **RESP:**
  - `s_rvalid_o[grant_r]=1`; all other `s_rvalid_o` bits are 0.
  - `s_rdata_o=rdata_r` and `s_rresp_o=rresp_r`, held stable until `s_rready_i[grant_r]`.
  - On that handshake: `last_grant_r <= grant_r`, go to `IDLE`.
- `s_rready_i` bits of non-granted masters are ignored.
- `s_arready_o` is 0 in every state except `IDLE`. Further requests wait; they are never dropped.
- The slave's `rresp` (OKAY, SLVERR or DECERR) is forwarded unmodified.
- `num_masters_p==1`: the arbiter degenerates to grant=0; the FSM is unchanged.

## Timing
- Reset (asserted asynchronously, released synchronously through the codebase's reset-release convention):
  - state=`IDLE`, `last_grant_r=num_masters_p-1` (master 0 wins first), `grant_r=0`, `addr_r=0`, `rdata_r=0`, `rresp_r=0`.
  - Output values: `s_arready_o`, `s_rvalid_o`, `m_arvalid_o` and `m_rready_o` are all 0; `s_rdata_o=0`, `s_rresp_o=0`, `m_araddr_o=0`.
- Reset mid-transaction: all outputs drop immediately, without waiting for a clock edge. The in-flight transaction is abandoned; the slave is reset in the same domain.
- Best-case latency, with an always-ready slave and master:
  - cycle 0: upstream AR handshake.
  - cycle 1: `m_arvalid_o` asserted, slave AR handshake.
  - cycle 2: `m_rvalid_i` accepted.
  - cycle 3: `s_rvalid_o` asserted and the R handshake completes.
  - Result: 4 cycles per read and a throughput of one read per 4 cycles.
- Back-to-back: a request pending at the R handshake of cycle 3 is granted in cycle 4. No bubble beyond the `IDLE` cycle.
- There are no combinational paths from `m_*` inputs to `s_*` outputs, or from `s_*` inputs to `m_*` outputs. The only combinational path is `s_arvalid_i` to `s_arready_o` in `IDLE`.
- Stalls of any length on `m_arready_i`, `m_rvalid_i` or `s_rready_i` are tolerated; all held signals stay constant during the stall.

## Structure
- The `rd_arb_state_e` enum (2-bit) and the `axil_resp_okay_gp` / `axil_resp_slverr_gp` / `axil_resp_decerr_gp` constants go in `bsg_axil_to_mcl_pkg`.
- One sub-module: `bsg_axil_rr_arbiter`.
  - Inputs: request vector and `last_grant_r`.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational. The grant pointer register lives in the parent.

## Test plan
- Reset, then master 0 reads 0x0000_1000 while the slave returns 0xDEAD_BEEF/OKAY with zero wait:
  - `s_rvalid_o=2'b01` in cycle 3 with `rdata=0xDEAD_BEEF`, `rresp=0`.
  - `m_araddr_o=0x1000` in cycle 1.
- Both masters request continuously for 6 reads:
  - grants alternate 0,1,0,1,0,1.
  - Each returned data equals the address-tagged slave model value for the correct master.
- Slave holds `m_arready_i=0` for 5 cycles and `m_rvalid_i=0` for 7 cycles:
  - `m_araddr_o` and `m_arvalid_o` are stable throughout.
  - The result is delivered and there are no extra AR handshakes.
- Granted master holds `s_rready_i=0` for 10 cycles while master 1 requests:
  - `s_rdata_o` is stable, `s_arready_o[1]` stays 0, and master 1 is granted the cycle after the R handshake.
- Slave returns `rresp=2'b11` (DECERR) for address 0x0000_F000:
  - `s_rresp_o=2'b11` goes to the requester only; the next read returns OKAY.
- Assert `reset_n_i` during `DATA`:
  - all valids and readies go to 0 immediately.
  - After release, master 0 has first priority and a fresh read completes normally.
